// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader state encoding and datapath widths.
package program_loader_pkg;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int IADDR_W = 10;
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;
endpackage

// File: rtl/program_loader_checksum.sv
// loader_checksum: running XOR of accepted payload bytes (clk, rst, clr, en, din -> csum).
module loader_checksum
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] csum
);
  always_ff @(posedge clk)
    csum <= (rst || clr) ? '0 : en ? csum ^ din : csum;
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte stream to 16-bit instruction memory writes; holds cpu_rst until a verified load (ports: start, byte_valid/byte_data/byte_ready in; wr_en/wr_addr/wr_data, cpu_rst, busy, done, error out).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = IADDR_W,
  parameter bit CSUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
  state_t            state;
  logic [BYTE_W-1:0] hi, len_hi, csum;
  logic [ADDR_W:0]   cnt, len;
  logic [16:0]       n;
  logic              acc, clr;
  assign byte_ready = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign busy       = byte_ready;
  assign done       = state == DONE;
  assign error      = state == ERR;
  assign cpu_rst    = state != DONE;
  assign acc        = byte_valid && byte_ready;
  assign clr        = start && (state inside {IDLE, DONE, ERR});
  assign n          = {1'b0, len_hi, byte_data};
  loader_checksum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (acc && (state inside {DATA_HI, DATA_LO})),
    .din  (byte_data),
    .csum (csum)
  );
  // wr_addr holds word k during its write strobe and steps once the strobe drops;
  // cnt is one bit wider so a full-depth frame is counted without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      hi      <= '0;
      len_hi  <= '0;
      cnt     <= '0;
      len     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      case (state)
        IDLE, DONE, ERR: if (clr) begin
          state   <= LEN_HI;
          cnt     <= '0;
          wr_addr <= '0;
        end
        LEN_HI: if (acc) begin
          len_hi <= byte_data;
          state  <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          len   <= n[ADDR_W:0];
          state <= (n == '0 || n > DEPTH) ? ERR : DATA_HI;
        end
        DATA_HI: if (acc) begin
          hi    <= byte_data;
          state <= DATA_LO;
        end
        DATA_LO: if (acc) begin
          wr_en   <= 1'b1;
          wr_data <= {hi, byte_data};
          cnt     <= cnt + 1'b1;
          state   <= (cnt + 1'b1 == len) ? CHECK : DATA_HI;
        end
        CHECK: if (acc) state <= (CSUM_EN && byte_data != csum) ? ERR : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized frame stimulus checked against a frame-level reference model.
module tb_program_loader;
  logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [7:0]  byte_data = 0;
  logic        byte_ready, wr_en, cpu_rst, busy, done, error;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        byte_ready0, wr_en0, cpu_rst0, busy0, done0, error0;
  logic [9:0]  wr_addr0;
  logic [15:0] wr_data0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] got_q[$], exp_q[$];
  bit          exp_ok;

  program_loader #(.ADDR_W(10), .CSUM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error));

  program_loader #(.ADDR_W(10), .CSUM_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .error(error0));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) got_q.push_back({6'b0, wr_addr, wr_data});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] f[$]);
    int n = {f[0], f[1]};
    logic [7:0] x = 0;
    exp_q.delete();
    exp_ok = 0;
    if (n == 0 || n > 1024) return;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({6'b0, 10'(k), f[2+2*k], f[3+2*k]});
      x ^= f[2+2*k] ^ f[3+2*k];
    end
    exp_ok = (f[2+2*n] == x);
  endtask

  task automatic build(input int n, input bit bad, output logic [7:0] f[$]);
    logic [7:0] x = 0, b;
    f.delete();
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(bad ? x ^ 8'(1 << $urandom_range(0, 7)) : x);
  endtask

  task automatic send(input logic [7:0] f[$], input bit gaps, input bit noise);
    foreach (f[i]) begin
      int t = 0;
      bit sent = 0;
      while (!sent) begin
        @(negedge clk);
        byte_data  = f[i];
        byte_valid = gaps ? ($urandom_range(0, 2) == 0) : 1'b1;
        start      = noise && ($urandom_range(0, 3) == 0);
        sent       = byte_valid && byte_ready;
        @(posedge clk);
        #1;
        byte_valid = 0;
        start      = 0;
        t++;
        if (!sent && t > 60) begin
          check("byte_timeout", 0, 1);
          return;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run(input string tag, input logic [7:0] f[$], input bit gaps, input bit noise);
    model(f);
    pulse_start();
    got_q.delete();
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_cpu_rst_start"}, cpu_rst, 1);
    send(f, gaps, noise);
    check({tag, "_done"}, done, exp_ok);
    check({tag, "_error"}, error, !exp_ok);
    check({tag, "_cpu_rst"}, cpu_rst, !exp_ok);
    check({tag, "_busy_end"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] good_f[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    logic [7:0] bad_f[$]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    logic [7:0] part_f[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    logic [7:0] len0_f[$] = '{8'h00, 8'h00};
    logic [7:0] lenx_f[$] = '{8'h04, 8'h01};
    logic [7:0] f[$];
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", byte_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk);
    rst = 0;
    byte_valid = 1;
    byte_data = 8'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_byte_ready", byte_ready, 0);
      check("idle_busy", busy, 0);
    end
    byte_valid = 0;
    run("good", good_f, 0, 0);
    check("nocs_good_done", done0, 1);
    run("badcs", bad_f, 0, 0);
    check("nocs_badcs_done", done0, 1);
    check("nocs_badcs_error", error0, 0);
    run("retry", good_f, 0, 0);
    run("len0", len0_f, 0, 0);
    run("len1025", lenx_f, 0, 0);
    run("gaps", good_f, 1, 0);
    pulse_start();
    send(part_f, 0, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_byte_ready", byte_ready, 0);
    @(negedge clk);
    rst = 0;
    run("after_rst", good_f, 0, 0);
    run("reload_noise", good_f, 1, 1);
    for (int r = 0; r < 8; r++) begin
      build($urandom_range(1, 8), $urandom_range(0, 1) == 1, f);
      run("rand", f, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    build(1024, 0, f);
    run("full", f, 0, 0);
    check("full_last_addr", got_q.size() > 0 ? got_q[got_q.size()-1][25:16] : 10'h0, 10'h3FF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
